// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-master SPI bus arbiter.
package spi_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OWN_HPS  = 2'd1,
    ST_OWN_NIOS = 2'd2,
    ST_GAP      = 2'd3
  } arb_state_t;

  // One-hot owner encoding, also the layout of the grant output.
  localparam logic [1:0] OWN_HPS  = 2'b01;
  localparam logic [1:0] OWN_NIOS = 2'b10;

  // Width of the saturating denial counter.
  localparam int DENY_CNT_W = 8;

endpackage

// File: rtl/spi_arb_sync.sv
// N-stage synchronizer for an active-low select line; resets to 1 (deselected).
module spi_arb_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the flop chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '1;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_bus_arbiter.sv
// Per-transaction arbiter sharing one SPI slave bus between the HPS and Nios
// masters. Optional grant watchdog is compiled in with SPI_ARB_TIMEOUT_EN.
//
// Handshake: a master requests by holding SS_n low while armed; it is armed
// again only after its synchronized SS_n has been seen high. A request that
// cannot be granted (bus owned, gap, or lost tie) is a denial and disarms the
// master, so a frame is either connected from its start or not at all.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int   SYNC_STAGES    = 2,
  parameter int   GAP_CYCLES     = 4,
  parameter int   TIMEOUT_CYCLES = 50000,
  parameter logic CPOL           = 1'b0
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  hps_sclk,
  input  logic                  hps_mosi,
  input  logic                  hps_ss_n,
  output logic                  hps_miso,
  input  logic                  nios_sclk,
  input  logic                  nios_mosi,
  input  logic                  nios_ss_n,
  output logic                  nios_miso,
  output logic                  spi_sclk,
  output logic                  spi_mosi,
  output logic                  spi_ss_n,
  input  logic                  spi_miso,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic [DENY_CNT_W-1:0] deny_cnt,
  output logic                  timeout,
  output arb_state_t            dbg_state
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic                  hps_ss_s, nios_ss_s;
  logic [1:0]            ss_s, req, win, deny_mask;
  logic [SYNC_STAGES:0]  live_q;
  logic                  primed, first_live, owner_ss_s, wdog_fire;
  logic [1:0]            armed_q, grant_q, last_owner_q;
  arb_state_t            state_q;
  logic                  busy_q;
  logic [GAP_W-1:0]      gap_q;
  logic [DENY_CNT_W-1:0] deny_q;

  spi_arb_sync #(.STAGES(SYNC_STAGES)) u_sync_hps (
    .clk_i (clk_clk), .rst_ni(reset_reset_n), .d_i(hps_ss_n),  .q_o(hps_ss_s)
  );
  spi_arb_sync #(.STAGES(SYNC_STAGES)) u_sync_nios (
    .clk_i (clk_clk), .rst_ni(reset_reset_n), .d_i(nios_ss_n), .q_o(nios_ss_s)
  );

  assign ss_s = {nios_ss_s, hps_ss_s};

  // Track when the synchronizer outputs carry real samples after reset, so a
  // select already low at reset release is treated as a frame in flight.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) live_q <= '0;
    else                live_q <= {live_q[SYNC_STAGES-1:0], 1'b1};
  end

  assign primed     = live_q[SYNC_STAGES];
  assign first_live = live_q[SYNC_STAGES-1] & ~primed;
  assign req        = primed ? (~ss_s & armed_q) : 2'b00;

  // Pick the winner in IDLE (round-robin on ties); every other request is denied.
  always_comb begin
    win = 2'b00;
    if (state_q == ST_IDLE) begin
      if (&req) win = (last_owner_q == OWN_HPS) ? OWN_NIOS : OWN_HPS;
      else      win = req;
    end
    deny_mask = req & ~win;
  end

  // Arm on a seen-high select; disarm on grant or denial.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)  armed_q <= 2'b11;
    else if (first_live) armed_q <= armed_q & ss_s;
    else                 armed_q <= (armed_q | ss_s) & ~(win | deny_mask);
  end

  assign owner_ss_s = (state_q == ST_OWN_HPS) ? hps_ss_s : nios_ss_s;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [31:0] to_cnt_q;
  logic        timeout_q;
  logic        in_own;

  assign in_own    = (state_q == ST_OWN_HPS) || (state_q == ST_OWN_NIOS);
  assign wdog_fire = in_own && (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  // Count owned cycles; held at zero outside ownership so entry starts at 0.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= in_own ? to_cnt_q + 32'd1 : 32'd0;
      timeout_q <= wdog_fire;
    end
  end

  assign timeout = timeout_q;
`else
  assign wdog_fire = 1'b0;
  // Watchdog compiled out: timeout is constant low for any limit value.
  if (TIMEOUT_CYCLES > 0) begin : g_wdog_off
    assign timeout = 1'b0;
  end else begin : g_wdog_off_nolimit
    assign timeout = 1'b0;
  end
`endif

  // Arbiter FSM with registered grant/busy and the saturating denial counter.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 2'b00;
      busy_q       <= 1'b0;
      last_owner_q <= OWN_NIOS;
      gap_q        <= '0;
      deny_q       <= '0;
    end else begin
      if ((|deny_mask) && (deny_q != '1)) deny_q <= deny_q + DENY_CNT_W'(1);
      case (state_q)
        ST_IDLE: begin
          if (win != 2'b00) begin
            state_q      <= (win == OWN_HPS) ? ST_OWN_HPS : ST_OWN_NIOS;
            grant_q      <= win;
            busy_q       <= 1'b1;
            last_owner_q <= win;
          end
        end
        ST_OWN_HPS, ST_OWN_NIOS: begin
          if (owner_ss_s || wdog_fire) begin
            state_q <= ST_GAP;
            grant_q <= 2'b00;
            gap_q   <= GAP_W'(GAP_CYCLES - 1);
          end
        end
        ST_GAP: begin
          if (gap_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Combinational pin mux: owner drives the slave, everyone else sees idle levels.
  always_comb begin
    spi_ss_n  = 1'b1;
    spi_sclk  = CPOL;
    spi_mosi  = 1'b0;
    hps_miso  = 1'b0;
    nios_miso = 1'b0;
    case (state_q)
      ST_OWN_HPS: begin
        spi_ss_n = hps_ss_n;
        spi_sclk = hps_sclk;
        spi_mosi = hps_mosi;
        hps_miso = spi_miso;
      end
      ST_OWN_NIOS: begin
        spi_ss_n  = nios_ss_n;
        spi_sclk  = nios_sclk;
        spi_mosi  = nios_mosi;
        nios_miso = spi_miso;
      end
      default: ;
    endcase
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign deny_cnt  = deny_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: mux table plus multi-cycle sequences.
module tb_spi_bus_arbiter;
  import spi_arb_pkg::*;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_CYC = 100;
`else
  localparam int TO_CYC = 50000;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hps_sclk, hps_mosi, hps_ss_n, hps_miso;
  logic       nios_sclk, nios_mosi, nios_ss_n, nios_miso;
  logic       spi_sclk, spi_mosi, spi_ss_n, spi_miso;
  logic [1:0] grant;
  logic       busy, timeout;
  logic [7:0] deny_cnt;
  arb_state_t dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  spi_bus_arbiter #(
    .SYNC_STAGES(2), .GAP_CYCLES(4), .TIMEOUT_CYCLES(TO_CYC), .CPOL(1'b0)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .hps_sclk(hps_sclk), .hps_mosi(hps_mosi), .hps_ss_n(hps_ss_n), .hps_miso(hps_miso),
    .nios_sclk(nios_sclk), .nios_mosi(nios_mosi), .nios_ss_n(nios_ss_n), .nios_miso(nios_miso),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n), .spi_miso(spi_miso),
    .grant(grant), .busy(busy), .deny_cnt(deny_cnt), .timeout(timeout), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    int         own;                       // 0 idle, 1 HPS owns, 2 Nios owns
    logic       hs, hm, ns, nm, sm;        // hps sclk/mosi, nios sclk/mosi, slave miso
    logic [4:0] exp_pins;                  // {spi_ss_n, spi_sclk, spi_mosi, hps_miso, nios_miso}
    logic [1:0] exp_grant;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance n clock cycles, landing 2ns after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic go_idle();
    hps_ss_n = 1'b1; nios_ss_n = 1'b1;
    hps_sclk = 1'b0; nios_sclk = 1'b0; hps_mosi = 1'b0; nios_mosi = 1'b0;
    tick(12);
  endtask

  task automatic take_bus(input int who);
    go_idle();
    if (who == 1) hps_ss_n = 1'b0;
    if (who == 2) nios_ss_n = 1'b0;
    tick(3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
  endtask

  initial begin
    int         cur_own;
    int         exp_deny;
    logic [15:0] tx_word;
    logic [15:0] rx_word;

    vecs[0] = '{0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'b10000, 2'b00};
    vecs[1] = '{0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'b10000, 2'b00};
    vecs[2] = '{1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'b01010, 2'b01};
    vecs[3] = '{1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00100, 2'b01};
    vecs[4] = '{1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'b01110, 2'b01};
    vecs[5] = '{1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'b00010, 2'b01};
    vecs[6] = '{2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00001, 2'b10};
    vecs[7] = '{2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'b01100, 2'b10};
    vecs[8] = '{2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'b01001, 2'b10};
    vecs[9] = '{2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'b00101, 2'b10};

    // Reset state
    rst_n = 1'b0;
    hps_sclk = 1'b0; hps_mosi = 1'b1; hps_ss_n = 1'b1;
    nios_sclk = 1'b0; nios_mosi = 1'b1; nios_ss_n = 1'b1;
    spi_miso = 1'b1;
    #1;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_deny", 32'(deny_cnt), 32'h0);
    check("reset_timeout", 32'(timeout), 32'h0);
    check("reset_pins", 32'({spi_ss_n, spi_sclk, spi_mosi, hps_miso, nios_miso}), 32'b10000);
    #20;
    rst_n = 1'b1;
    tick(5);

    // Pin mux table
    cur_own = -1;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].own != cur_own) begin
        take_bus(vecs[i].own);
        cur_own = vecs[i].own;
      end
      hps_sclk = vecs[i].hs; hps_mosi = vecs[i].hm;
      nios_sclk = vecs[i].ns; nios_mosi = vecs[i].nm;
      spi_miso = vecs[i].sm;
      #1;
      check($sformatf("mux_pins[%0d]", i),
            32'({spi_ss_n, spi_sclk, spi_mosi, hps_miso, nios_miso}), 32'(vecs[i].exp_pins));
      check($sformatf("mux_grant[%0d]", i), 32'(grant), 32'(vecs[i].exp_grant));
    end

    // Single HPS frame
    go_idle();
    hps_ss_n = 1'b0;
    tick(2);
    check("frame_grant_early", 32'(grant), 32'h0);
    tick(1);
    check("frame_grant", 32'(grant), 32'h1);
    check("frame_busy", 32'(busy), 32'h1);
    tx_word = 16'hA5C3;
    rx_word = '0;
    for (int b = 15; b >= 0; b--) begin
      hps_mosi = tx_word[b];
      spi_miso = 1'($urandom_range(0, 1));
      tick(1);
      hps_sclk = 1'b1;
      #1;
      rx_word = {rx_word[14:0], spi_mosi};
      check($sformatf("frame_miso[%0d]", b), 32'(hps_miso), 32'(spi_miso));
      check($sformatf("frame_nmiso[%0d]", b), 32'(nios_miso), 32'h0);
      tick(1);
      hps_sclk = 1'b0;
    end
    check("frame_rx", 32'(rx_word), 32'hA5C3);
    hps_ss_n = 1'b1;
    tick(3);
    check("frame_gap_state", 32'(dbg_state), 32'(ST_GAP));
    check("frame_gap_grant", 32'(grant), 32'h0);
    tick(3);
    check("frame_gap_busy", 32'(busy), 32'h1);
    tick(1);
    check("frame_idle_busy", 32'(busy), 32'h0);

    // Simultaneous request after reset
    do_reset();
    hps_ss_n = 1'b0; nios_ss_n = 1'b0;
    tick(3);
    check("tie1_grant", 32'(grant), 32'h1);
    check("tie1_deny", 32'(deny_cnt), 32'h1);
    hps_ss_n = 1'b1;
    tick(10);
    check("tie1_nios_blocked", 32'(grant), 32'h0);
    check("tie1_deny_hold", 32'(deny_cnt), 32'h1);
    nios_ss_n = 1'b1;
    tick(4);
    nios_ss_n = 1'b0;
    tick(3);
    check("tie1_nios_retry", 32'(grant), 32'h2);
    nios_ss_n = 1'b1;
    tick(10);
    hps_ss_n = 1'b0; nios_ss_n = 1'b0;
    tick(3);
    check("tie2_grant", 32'(grant), 32'h1);
    check("tie2_deny", 32'(deny_cnt), 32'h2);

    // Nios falls while HPS owns
    take_bus(1);
    nios_ss_n = 1'b0;
    spi_miso = 1'b1;
    tick(3);
    check("late_deny", 32'(deny_cnt), 32'h3);
    check("late_grant", 32'(grant), 32'h1);
    check("late_ss", 32'(spi_ss_n), 32'h0);
    check("late_nmiso", 32'(nios_miso), 32'h0);
    hps_ss_n = 1'b1;
    tick(12);
    check("late_not_granted", 32'(grant), 32'h0);
    check("late_idle", 32'(busy), 32'h0);
    nios_ss_n = 1'b1;
    tick(4);
    nios_ss_n = 1'b0;
    tick(3);
    check("late_retry", 32'(grant), 32'h2);

    // Reset mid-frame
    take_bus(1);
    hps_sclk = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ss", 32'(spi_ss_n), 32'h1);
    check("rst_mid_sclk", 32'(spi_sclk), 32'h0);
    check("rst_mid_grant", 32'(grant), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_deny", 32'(deny_cnt), 32'h0);
    tick(2);
    rst_n = 1'b1;
    hps_sclk = 1'b0;
    tick(10);
    check("rst_no_regrant", 32'(grant), 32'h0);
    hps_ss_n = 1'b1;
    tick(4);
    hps_ss_n = 1'b0;
    tick(3);
    check("rst_regrant", 32'(grant), 32'h1);

`ifndef SPI_ARB_TIMEOUT_EN
    // Deny saturation while HPS holds the bus
    exp_deny = 0;
    for (int k = 0; k < 300; k++) begin
      nios_ss_n = 1'b0;
      tick(3);
      nios_ss_n = 1'b1;
      tick(3);
      if (exp_deny < 255) exp_deny++;
      if (k == 9) check("sat_deny_10", 32'(deny_cnt), 32'(exp_deny));
    end
    check("sat_deny_255", 32'(deny_cnt), 32'(exp_deny));
    check("sat_grant_held", 32'(grant), 32'h1);
    check("sat_no_timeout", 32'(timeout), 32'h0);
`else
    // Watchdog
    take_bus(1);
    check("wd_grant", 32'(grant), 32'h1);
    tick(99);
    check("wd_before", 32'(timeout), 32'h0);
    check("wd_before_grant", 32'(grant), 32'h1);
    tick(1);
    check("wd_pulse", 32'(timeout), 32'h1);
    check("wd_release_grant", 32'(grant), 32'h0);
    check("wd_release_ss", 32'(spi_ss_n), 32'h1);
    tick(1);
    check("wd_pulse_end", 32'(timeout), 32'h0);
    tick(3);
    check("wd_idle", 32'(busy), 32'h0);
    nios_ss_n = 1'b0;
    tick(3);
    check("wd_nios_grant", 32'(grant), 32'h2);
    exp_deny = 0;
`endif

    go_idle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
